// File: rtl/confreg_sram_responder.sv
// Configuration-register responder on the data-side SRAM-like bus.
// Holds scratch, LED, number display, switch readback, a free-running timer and a key counter.
module confreg_sram_responder #(
  parameter logic [15:0] BASE_HI = 16'h1faf,
  parameter int unsigned LED_W   = 16,
  parameter int unsigned SW_W    = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  led,
  output logic [31:0]       num_data,
  input  logic [SW_W-1:0]   switch,
  input  logic              btn_key
);

  localparam int unsigned DW    = 32;
  localparam int unsigned KEY_W = 16;
  localparam int unsigned NCR   = 8;

  localparam logic [15:0] OFF_CR0   = 16'h8000;
  localparam logic [15:0] OFF_TIMER = 16'he000;
  localparam logic [15:0] OFF_LED   = 16'hf000;
  localparam logic [15:0] OFF_NUM   = 16'hf010;
  localparam logic [15:0] OFF_SW    = 16'hf020;
  localparam logic [15:0] OFF_KEY   = 16'hf030;

  logic [DW-1:0]    cr [NCR];
  logic [DW-1:0]    timer;
  logic [LED_W-1:0] led_reg;
  logic [DW-1:0]    num_reg;
  logic [KEY_W-1:0] key_cnt;
  logic [SW_W-1:0]  sw_s1, sw_s2;
  logic             key_s1, key_s2;
  logic [2:0]       deb_sh;
  logic             deb_level;

  logic             sel_c, wr_c, rd_c, cr_hit_c, key_edge_c;
  logic [2:0]       cr_idx_c;
  logic             wr_cr_c, wr_timer_c, wr_led_c, wr_num_c, wr_key_c;
  logic [DW-1:0]    rd_val_c;
  logic             unused_addr_bits_c;

  // Byte-lane merge of new write data into an existing word
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [3:0]    be);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign unused_addr_bits_c = ^addr[1:0];

  // Address decode and write strobes
  always_comb begin
    sel_c      = en & (addr[31:16] == BASE_HI);
    wr_c       = sel_c & (wen != 4'b0000);
    rd_c       = sel_c & (wen == 4'b0000);
    cr_hit_c   = (addr[15:5] == OFF_CR0[15:5]);
    cr_idx_c   = addr[4:2];
    wr_cr_c    = wr_c & cr_hit_c;
    wr_timer_c = wr_c & (addr[15:2] == OFF_TIMER[15:2]);
    wr_led_c   = wr_c & (addr[15:2] == OFF_LED[15:2]);
    wr_num_c   = wr_c & (addr[15:2] == OFF_NUM[15:2]);
    wr_key_c   = wr_c & (addr[15:2] == OFF_KEY[15:2]);
    key_edge_c = (deb_sh == 3'b111) & ~deb_level;
  end

  // Read mux over pre-update register contents
  always_comb begin
    rd_val_c = '0;
    if (cr_hit_c) begin
      rd_val_c = cr[cr_idx_c];
    end else begin
      case (addr[15:2])
        OFF_TIMER[15:2]: rd_val_c = timer;
        OFF_LED[15:2]:   rd_val_c = DW'(led_reg);
        OFF_NUM[15:2]:   rd_val_c = num_reg;
        OFF_SW[15:2]:    rd_val_c = DW'(sw_s2);
        OFF_KEY[15:2]:   rd_val_c = DW'(key_cnt);
        default:         rd_val_c = '0;
      endcase
    end
  end

  // Bus-visible registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata   <= '0;
      timer   <= '0;
      led_reg <= '1;
      num_reg <= '0;
      key_cnt <= '0;
      for (int i = 0; i < NCR; i++) cr[i] <= '0;
    end else begin
      if (rd_c) rdata <= rd_val_c;
      if (wr_cr_c) cr[cr_idx_c] <= merge(cr[cr_idx_c], wdata, wen);
      if (wr_timer_c) timer <= merge(timer, wdata, wen);
      else            timer <= timer + DW'(1);
      if (wr_led_c) led_reg <= LED_W'(merge(DW'(led_reg), wdata, wen));
      if (wr_num_c) num_reg <= merge(num_reg, wdata, wen);
      // Clear beats a coincident key edge; count saturates
      if (wr_key_c) key_cnt <= '0;
      else if (key_edge_c && (key_cnt != '1)) key_cnt <= key_cnt + KEY_W'(1);
    end
  end

  // Input synchronizers and key debounce
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      key_s1    <= 1'b0;
      key_s2    <= 1'b0;
      deb_sh    <= '0;
      deb_level <= 1'b0;
    end else begin
      sw_s1  <= switch;
      sw_s2  <= sw_s1;
      key_s1 <= btn_key;
      key_s2 <= key_s1;
      deb_sh <= {deb_sh[1:0], key_s2};
      if (deb_sh == 3'b111)      deb_level <= 1'b1;
      else if (deb_sh == 3'b000) deb_level <= 1'b0;
    end
  end

  assign led      = ~led_reg;
  assign num_data = num_reg;

endmodule

// File: tb/tb_confreg_sram_responder.sv
// Directed bench for confreg_sram_responder with a read-data scoreboard.
module tb_confreg_sram_responder;

  localparam logic [31:0] A_CR0   = 32'h1faf_8000;
  localparam logic [31:0] A_CR3   = 32'h1faf_800c;
  localparam logic [31:0] A_CR7   = 32'h1faf_801c;
  localparam logic [31:0] A_HOLE  = 32'h1faf_8020;
  localparam logic [31:0] A_TIMER = 32'h1faf_e000;
  localparam logic [31:0] A_LED   = 32'h1faf_f000;
  localparam logic [31:0] A_NUM   = 32'h1faf_f010;
  localparam logic [31:0] A_SW    = 32'h1faf_f020;
  localparam logic [31:0] A_KEY   = 32'h1faf_f030;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [31:0] num_data;
  logic [7:0]  switch;
  logic        btn_key;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  int          total  = 0;
  int          passed = 0;

  confreg_sram_responder dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .wen      (wen),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .led      (led),
    .num_data (num_data),
    .switch   (switch),
    .btn_key  (btn_key)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain();
    logic [31:0] e;
    string       t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, rdata, e);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    en = 1'b1; wen = be; addr = a; wdata = d;
    cycle();
    en = 1'b0; wen = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    en = 1'b1; wen = 4'h0; addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    cycle();
    en = 1'b0;
    drain();
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
    switch = 8'h00; btn_key = 1'b0;
    idle(3);
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", 32'(led), 32'h0);
    check("reset_num", num_data, 32'h0);
    resetn = 1'b1;

    // Partial byte write
    wr(A_CR3, 32'h1122_3344, 4'hf);
    wr(A_CR3, 32'haabb_ccdd, 4'b0101);
    rd(A_CR3, 32'h11bb_33dd, "cr3_byte_merge");

    // Display outputs
    wr(A_NUM, 32'h1234_5678, 4'hf);
    check("num_data", num_data, 32'h1234_5678);
    wr(A_LED, 32'hffff_00ff, 4'hf);
    check("led_pins", 32'(led), 32'h0000_ff00);
    check("rdata_hold_on_write", rdata, 32'h11bb_33dd);
    rd(A_LED, 32'h0000_00ff, "led_readback");

    // Timer write wins, then wraps across back-to-back reads
    wr(A_TIMER, 32'hffff_fffe, 4'hf);
    rd(A_TIMER, 32'hffff_fffe, "timer_b2b_0");
    rd(A_TIMER, 32'hffff_ffff, "timer_b2b_1");
    rd(A_TIMER, 32'h0000_0000, "timer_wrap");

    // Scratch boundaries and unmapped offsets
    wr(A_CR7, 32'hcafe_f00d, 4'hf);
    wr(A_HOLE, 32'h1234_5678, 4'hf);
    rd(A_CR7, 32'hcafe_f00d, "cr7");
    rd(A_CR0, 32'h0000_0000, "cr0_untouched");
    rd(A_HOLE, 32'h0000_0000, "hole_above_cr7");
    rd(A_CR3, 32'h11bb_33dd, "cr3_before_unsel");
    wr(32'h1fae_800c, 32'hdead_beef, 4'hf);
    check("unsel_write_rdata_hold", rdata, 32'h11bb_33dd);
    rd(A_CR3, 32'h11bb_33dd, "cr3_after_unsel");
    rd(32'h1faf_4000, 32'h0000_0000, "unmapped_4000");
    en = 1'b1; wen = 4'h0; addr = 32'h1fae_8000;
    cycle();
    en = 1'b0;
    check("unsel_read_hold", rdata, 32'h0);

    // Key debounce and counter
    btn_key = 1'b1; idle(2); btn_key = 1'b0; idle(8);
    rd(A_KEY, 32'h0, "key_short_pulse");
    btn_key = 1'b1; idle(10); btn_key = 1'b0; idle(8);
    rd(A_KEY, 32'h1, "key_long_press");
    wr(A_KEY, 32'h0000_0000, 4'h1);
    rd(A_KEY, 32'h0, "key_clear");

    // Switch synchronizer
    switch = 8'ha5; idle(3);
    rd(A_SW, 32'h0000_00a5, "switch_read");

    // Reset in the middle of a read
    en = 1'b1; wen = 4'h0; addr = A_CR3;
    resetn = 1'b0;
    #1;
    check("midreset_rdata", rdata, 32'h0);
    check("midreset_led", 32'(led), 32'h0);
    check("midreset_num", num_data, 32'h0);
    cycle();
    en = 1'b0;
    cycle();
    resetn = 1'b1;
    check("rdata_after_release", rdata, 32'h0);
    en = 1'b1; wen = 4'h0; addr = A_TIMER;
    cycle();
    en = 1'b0;
    total++;
    assert (rdata <= 32'd2) passed++;
    else $error("FAIL timer_after_reset: observed %h expected <= 00000002", rdata);
    rd(A_CR3, 32'h0, "cr3_after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
